// File: rtl/coin_accumulator_pkg.sv
// Shared encodings for the coin accumulator slice: session states, coin codes,
// coin values and the default saturation ceiling of the accumulated total.
package coin_accumulator_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COLLECT  = 2'd1,
      ST_DISPENSE = 2'd2,
      ST_PAYOUT   = 2'd3
   } state_t;

   localparam logic [1:0] COIN_1   = 2'b00;
   localparam logic [1:0] COIN_2   = 2'b01;
   localparam logic [1:0] COIN_5   = 2'b10;
   localparam logic [1:0] COIN_BAD = 2'b11;

   localparam logic [3:0] VAL_1 = 4'd1;
   localparam logic [3:0] VAL_2 = 4'd2;
   localparam logic [3:0] VAL_5 = 4'd5;

   localparam int DEF_MAX_TOTAL = 15;

   // Unknown codes map to zero so a stray value can never add credit.
   function automatic logic [3:0] coin_value(input logic [1:0] code);
      case (code)
         COIN_1:  return VAL_1;
         COIN_2:  return VAL_2;
         COIN_5:  return VAL_5;
         default: return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/coin_decoder.sv
// Coin denomination decoder: combinational, zero latency, no flow control.
// Maps the 2-bit slot code to its credit value and flags the reject code.
module coin_decoder
   import coin_accumulator_pkg::*;
(
   input  logic [1:0] coin_code,
   output logic [3:0] value,
   output logic       invalid
);

   assign value   = coin_value(coin_code);
   assign invalid = (coin_code == COIN_BAD);

endmodule

// File: rtl/coin_accumulator.sv
// Purchase session controller: collects coins, releases product, pays change or refund.
// Every output is registered (one cycle after the sampling edge); actuators hold off via done_ack/change_ack.
module coin_accumulator
   import coin_accumulator_pkg::*;
#(
   parameter int MAX_TOTAL      = DEF_MAX_TOTAL,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int TMR_W          = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       coin_valid,
   input  logic [1:0] coin_code,
   input  logic [3:0] price,
   input  logic       sel_valid,
   input  logic       cancel,
   input  logic       done_ack,
   input  logic       change_ack,
   output logic [3:0] total,
   output logic       coin_reject,
   output logic       dispense,
   output logic [3:0] change,
   output logic       change_valid,
   output logic       busy
);

   localparam logic [4:0]       MAX_SUM  = 5'(MAX_TOTAL);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   logic [TMR_W-1:0] timer;
   logic [3:0]       price_q;
   logic [3:0]       coin_val;
   logic             coin_bad;

   coin_decoder u_coin_decoder (
      .coin_code (coin_code),
      .value     (coin_val),
      .invalid   (coin_bad)
   );

   // Sum kept at 5 bits so the ceiling check can never be fooled by wrap.
   logic [4:0] sum;
   logic       coin_ok;
   logic       fits;
   logic       quit;
   logic       buy;
   logic [3:0] remain;

   assign sum     = {1'b0, total} + {1'b0, coin_val};
   assign coin_ok = coin_valid && !coin_bad;
   assign fits    = (sum <= MAX_SUM);
   assign quit    = cancel || ((timer == TMR_LAST) && !coin_valid);
   assign buy     = sel_valid && (price != 4'd0) && (total >= price);
   assign remain  = total - price_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         timer        <= '0;
         price_q      <= '0;
         total        <= '0;
         coin_reject  <= 1'b0;
         dispense     <= 1'b0;
         change       <= '0;
         change_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         coin_reject <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (coin_ok) begin
                  total <= coin_val;
                  timer <= '0;
                  state <= ST_COLLECT;
                  busy  <= 1'b1;
               end else if (coin_valid) begin
                  coin_reject <= 1'b1;
               end
            end
            ST_COLLECT: begin
               // Purchase outranks coin acceptance: a coin racing the buy goes back.
               if (quit) begin
                  coin_reject <= coin_valid;
                  if (total != 4'd0) begin
                     change       <= total;
                     change_valid <= 1'b1;
                     state        <= ST_PAYOUT;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end else if (buy) begin
                  coin_reject <= coin_valid;
                  dispense    <= 1'b1;
                  price_q     <= price;
                  state       <= ST_DISPENSE;
               end else if (coin_ok && fits) begin
                  total <= sum[3:0];
                  timer <= '0;
               end else begin
                  coin_reject <= coin_valid;
                  timer       <= timer + TMR_W'(1);
               end
            end
            ST_DISPENSE: begin
               coin_reject <= coin_valid;
               if (done_ack) begin
                  dispense <= 1'b0;
                  change   <= remain;
                  if (remain != 4'd0) begin
                     change_valid <= 1'b1;
                     state        <= ST_PAYOUT;
                  end else begin
                     total <= '0;
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            ST_PAYOUT: begin
               coin_reject <= coin_valid;
               if (change_ack) begin
                  change_valid <= 1'b0;
                  change       <= '0;
                  total        <= '0;
                  state        <= ST_IDLE;
                  busy         <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_coin_accumulator.sv
// Self-checking bench for coin_accumulator: directed vector table, corner sequences, random vs model.
module tb_coin_accumulator;

   localparam int TO   = 8;
   localparam int TW   = 4;
   localparam int MAXT = 15;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       coin_valid = 1'b0;
   logic [1:0] coin_code = 2'b00;
   logic [3:0] price = 4'd0;
   logic       sel_valid = 1'b0;
   logic       cancel = 1'b0;
   logic       done_ack = 1'b0;
   logic       change_ack = 1'b0;
   logic [3:0] total;
   logic       coin_reject;
   logic       dispense;
   logic [3:0] change;
   logic       change_valid;
   logic       busy;

   always #5 clk = ~clk;

   coin_accumulator #(
      .MAX_TOTAL      (MAXT),
      .TIMEOUT_CYCLES (TO),
      .TMR_W          (TW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .coin_valid   (coin_valid),
      .coin_code    (coin_code),
      .price        (price),
      .sel_valid    (sel_valid),
      .cancel       (cancel),
      .done_ack     (done_ack),
      .change_ack   (change_ack),
      .total        (total),
      .coin_reject  (coin_reject),
      .dispense     (dispense),
      .change       (change),
      .change_valid (change_valid),
      .busy         (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       cv;
      logic [1:0] code;
      logic [3:0] pr;
      logic       sel;
      logic       cn;
      logic       da;
      logic       ca;
      int         e_total;
      int         e_rej;
      int         e_disp;
      int         e_chg;
      int         e_chgv;
      int         e_busy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic cv, logic [1:0] code, logic [3:0] pr, logic sel,
                               logic cn, logic da, logic ca, int t, int rj, int dp,
                               int cg, int cgv, int bz);
      vec_t v;
      v.cv = cv; v.code = code; v.pr = pr; v.sel = sel; v.cn = cn; v.da = da; v.ca = ca;
      v.e_total = t; v.e_rej = rj; v.e_disp = dp; v.e_chg = cg; v.e_chgv = cgv; v.e_busy = bz;
      return v;
   endfunction

   task automatic chk(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(string tag, int t, int rj, int dp, int cg, int cgv, int bz);
      chk({tag, ".total"}, int'(total), t);
      chk({tag, ".coin_reject"}, int'(coin_reject), rj);
      chk({tag, ".dispense"}, int'(dispense), dp);
      chk({tag, ".change"}, int'(change), cg);
      chk({tag, ".change_valid"}, int'(change_valid), cgv);
      chk({tag, ".busy"}, int'(busy), bz);
   endtask

   task automatic drive(logic cv, logic [1:0] code, logic [3:0] pr, logic sel,
                        logic cn, logic da, logic ca);
      coin_valid = cv; coin_code = code; price = pr; sel_valid = sel;
      cancel = cn; done_ack = da; change_ack = ca;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      coin_valid = 1'b0; cancel = 1'b0; done_ack = 1'b0; change_ack = 1'b0;
   endtask

   task automatic do_reset();
      drive(0, 2'b00, 4'd0, 0, 0, 0, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_all("reset", 0, 0, 0, 0, 0, 0);
      reset = 1'b0;
   endtask

   // Reference model: the outputs themselves describe the session phase.
   int m_total, m_rej, m_disp, m_chg, m_chgv, m_busy, m_price, m_idle;

   task automatic model_clear();
      m_total = 0; m_rej = 0; m_disp = 0; m_chg = 0; m_chgv = 0; m_busy = 0;
      m_price = 0; m_idle = 0;
   endtask

   task automatic model_step(bit cv, int code, int pr, bit sel, bit cn, bit da, bit ca);
      int  val;
      bit  bad;
      bit  timeout;
      int  left;
      val = (code == 0) ? 1 : (code == 1) ? 2 : (code == 2) ? 5 : 0;
      bad = (code == 3);
      m_rej = 0;
      if (m_disp != 0) begin
         m_rej = cv;
         if (da) begin
            m_disp = 0;
            left = m_total - m_price;
            m_chg = left;
            if (left != 0) m_chgv = 1;
            else begin m_total = 0; m_busy = 0; end
         end
      end else if (m_chgv != 0) begin
         m_rej = cv;
         if (ca) begin m_chgv = 0; m_chg = 0; m_total = 0; m_busy = 0; end
      end else if (m_busy == 0) begin
         if (cv && bad) m_rej = 1;
         else if (cv) begin m_total = val; m_idle = 0; m_busy = 1; end
      end else begin
         timeout = !cv && ((m_idle % (1 << TW)) == TO - 1);
         if (cn || timeout) begin
            m_rej = cv;
            if (m_total > 0) begin m_chg = m_total; m_chgv = 1; end
            else m_busy = 0;
         end else if (sel && pr != 0 && m_total >= pr) begin
            m_rej = cv; m_disp = 1; m_price = pr;
         end else if (cv && !bad && m_total + val <= MAXT) begin
            m_total = m_total + val; m_idle = 0;
         end else begin
            m_rej = cv; m_idle++;
         end
      end
   endtask

   initial begin
      // Directed table: {cv, code, price, sel, cancel, done_ack, change_ack} -> outputs after the edge.
      vecs.push_back(mk(1, 2'b10, 4'd7, 1, 0, 0, 0,  5, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 2'b01, 4'd7, 1, 0, 0, 0,  7, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 2'b00, 4'd7, 1, 0, 0, 0,  7, 0, 1, 0, 0, 1));
      vecs.push_back(mk(0, 2'b00, 4'd7, 1, 0, 0, 0,  7, 0, 1, 0, 0, 1));
      vecs.push_back(mk(0, 2'b00, 4'd7, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 2'b10, 4'd3, 0, 0, 0, 0,  5, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 2'b00, 4'd3, 0, 0, 0, 0,  6, 0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 2'b00, 4'd3, 1, 0, 0, 0,  6, 0, 1, 0, 0, 1));
      vecs.push_back(mk(0, 2'b00, 4'd3, 1, 0, 1, 0,  6, 0, 0, 3, 1, 1));
      vecs.push_back(mk(0, 2'b00, 4'd3, 1, 0, 0, 0,  6, 0, 0, 3, 1, 1));
      vecs.push_back(mk(0, 2'b00, 4'd3, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 2'b10, 4'd0, 0, 0, 0, 0,  5, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 2'b10, 4'd0, 0, 0, 0, 0, 10, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 2'b01, 4'd0, 0, 0, 0, 0, 12, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 2'b10, 4'd0, 0, 0, 0, 0, 12, 1, 0, 0, 0, 1));
      vecs.push_back(mk(1, 2'b01, 4'd0, 0, 0, 0, 0, 14, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 2'b00, 4'd0, 0, 0, 0, 0, 15, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 2'b00, 4'd0, 0, 0, 0, 0, 15, 1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 2'b00, 4'd0, 0, 1, 0, 0, 15, 0, 0, 15, 1, 1));
      vecs.push_back(mk(0, 2'b00, 4'd0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 2'b10, 4'd0, 0, 0, 0, 0,  5, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 2'b00, 4'd0, 0, 0, 0, 0,  6, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 2'b01, 4'd0, 0, 1, 0, 0,  6, 1, 0, 6, 1, 1));
      vecs.push_back(mk(0, 2'b00, 4'd0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(1, 2'b11, 4'd0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'b00, 4'd0, 0, 1, 0, 0,  0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 2'b00, 4'd0, 0, 0, 1, 1,  0, 0, 0, 0, 0, 0));

      do_reset();
      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].cv, vecs[i].code, vecs[i].pr, vecs[i].sel,
               vecs[i].cn, vecs[i].da, vecs[i].ca);
         tick();
         check_all($sformatf("vec%0d", i), vecs[i].e_total, vecs[i].e_rej, vecs[i].e_disp,
                   vecs[i].e_chg, vecs[i].e_chgv, vecs[i].e_busy);
      end

      // Inactivity refund after TO idle cycles.
      drive(1, 2'b01, 4'd0, 0, 0, 0, 0);
      tick();
      check_all("to_coin", 2, 0, 0, 0, 0, 1);
      for (int k = 1; k < TO; k++) begin
         tick();
         chk($sformatf("to_idle%0d.change_valid", k), int'(change_valid), 0);
      end
      tick();
      check_all("to_fire", 2, 0, 0, 2, 1, 1);
      drive(0, 2'b00, 4'd0, 0, 0, 0, 1);
      tick();
      check_all("to_ack", 0, 0, 0, 0, 0, 0);

      // A coin on the seventh idle cycle restarts the count.
      drive(1, 2'b01, 4'd0, 0, 0, 0, 0);
      tick();
      for (int k = 1; k < TO - 1; k++) tick();
      drive(1, 2'b00, 4'd0, 0, 0, 0, 0);
      tick();
      check_all("to_restart", 3, 0, 0, 0, 0, 1);
      for (int k = 1; k < TO; k++) begin
         tick();
         chk($sformatf("to_re%0d.change_valid", k), int'(change_valid), 0);
      end
      tick();
      check_all("to_refire", 3, 0, 0, 3, 1, 1);
      drive(0, 2'b00, 4'd0, 0, 0, 0, 1);
      tick();

      // Asynchronous reset while dispensing.
      drive(1, 2'b10, 4'd5, 1, 0, 0, 0);
      tick();
      tick();
      check_all("pre_arst", 5, 0, 1, 0, 0, 1);
      #3;
      reset = 1'b1;
      #1;
      check_all("arst", 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(0, 2'b00, 4'd0, 0, 0, 0, 0);

      // Randomized traffic against the model.
      do_reset();
      model_clear();
      begin
         bit quiet;
         bit r_sel;
         int r_pr;
         quiet = 1'b0;
         r_sel = 1'b0;
         r_pr = 0;
         for (int c = 0; c < 3000; c++) begin
            bit r_cv, r_cn, r_da, r_ca;
            int r_code;
            if (c % 40 == 0) quiet = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 19) == 0) begin
               r_sel = ~r_sel;
               if (r_sel) r_pr = $urandom_range(0, 15);
            end
            r_cv   = quiet ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 2) == 0);
            r_code = $urandom_range(0, 3);
            r_cn   = ($urandom_range(0, 39) == 0);
            r_da   = ($urandom_range(0, 3) == 0);
            r_ca   = ($urandom_range(0, 3) == 0);
            drive(r_cv, 2'(r_code), 4'(r_pr), r_sel, r_cn, r_da, r_ca);
            model_step(r_cv, r_code, r_pr, r_sel, r_cn, r_da, r_ca);
            tick();
            check_all($sformatf("rnd%0d", c), m_total, m_rej, m_disp, m_chg, m_chgv, m_busy);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
